// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one shared memory port with starvation guard
// Optional watchdog abort on missing mem_ack: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic        err
);
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

    state_t        r_state;
    logic          r_mem_req, r_mem_we;
    logic [31:0]   r_mem_addr, r_mem_wdata;
    logic          r_if_ready, r_dm_ready;
    logic [31:0]   r_if_rdata, r_dm_rdata;
    logic [SW-1:0] r_starve;

    logic          w_dm_elig, w_if_elig, w_starved, w_grant_dm, w_grant_if;
    logic          w_done;
    logic [31:0]   w_rsp;

    // A port whose ready is high this cycle was just served and must not be re-granted.
    assign w_dm_elig  = dm_req & ~r_dm_ready;
    assign w_if_elig  = if_req & ~r_if_ready;
    assign w_starved  = (r_starve == STARVE_LIM) & w_if_elig;
    assign w_grant_dm = w_dm_elig & ~w_starved;
    assign w_grant_if = w_if_elig & ~w_grant_dm;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_err;
    logic          w_tmo;

    assign w_tmo  = (r_tmo_cnt == TMO_LIM);
    assign w_done = mem_ack | w_tmo;
    assign w_rsp  = mem_ack ? mem_rdata : 32'hDEADBEEF;
    assign err    = r_err;
`else
    assign w_done = mem_ack;
    assign w_rsp  = mem_rdata;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_if_rdata  <= 32'h0;
            r_dm_rdata  <= 32'h0;
            r_starve    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_dm) begin
                        r_state     <= DATA;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= dm_we;
                        r_mem_addr  <= dm_addr;
                        r_mem_wdata <= dm_wdata;
                        if (if_req && (r_starve != STARVE_LIM))
                            r_starve <= r_starve + 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                        r_tmo_cnt   <= '0;
`endif
                    end else if (w_grant_if) begin
                        r_state     <= FETCH;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= 32'h0;
                        r_starve    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
                        r_tmo_cnt   <= '0;
`endif
                    end
                end
                DATA, FETCH: begin
                    if (w_done) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        if (r_state == DATA) begin
                            r_dm_rdata <= w_rsp;
                            r_dm_ready <= 1'b1;
                        end else begin
                            r_if_rdata <= w_rsp;
                            r_if_ready <= 1'b1;
                        end
`ifdef MEM_ARB_TIMEOUT_EN
                        if (!mem_ack)
                            r_err <= 1'b1;
`endif
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_ready  = r_if_ready;
    assign dm_ready  = r_dm_ready;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign stall     = (if_req & ~r_if_ready) | (dm_req & ~r_dm_ready);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ready, dm_ready, mem_req, mem_we, stall, err;

    int n_chk  = 0;
    int n_fail = 0;

    mem_port_arbiter #(.STARVE_MAX(4), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, if_req;
        logic [31:0] if_addr;
        logic        dm_req, dm_we;
        logic [31:0] dm_addr, dm_wdata, mem_rdata;
        logic        mem_ack;
        logic        e_mem_req, e_mem_we;
        logic [31:0] e_mem_addr, e_mem_wdata;
        logic        e_if_ready;
        logic [31:0] e_if_rdata;
        logic        e_dm_ready;
        logic [31:0] e_dm_rdata;
        logic        e_stall;
    } vec_t;

    vec_t vecs[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    localparam logic [31:0] Z = 32'h0;
    localparam logic O = 1'b1;
    localparam logic N = 1'b0;

    logic grants[5];
    int   ng;
    logic prev;
    int   hi;
    logic seen_ready;

    initial begin
        // Fields: rst if_req if_addr dm_req dm_we dm_addr dm_wdata mem_rdata mem_ack |
        //         mem_req mem_we mem_addr mem_wdata if_ready if_rdata dm_ready dm_rdata stall
        vecs[0]  = '{O, N, Z,          N, N, Z,       Z,       Z,            N, N, N, Z,          Z,       N, Z,            N, Z,            N};
        vecs[1]  = '{N, O, 32'h100,    N, N, Z,       Z,       Z,            N, O, N, 32'h100,    Z,       N, Z,            N, Z,            O};
        vecs[2]  = '{N, O, 32'h100,    N, N, Z,       Z,       32'h2002000A, O, N, N, 32'h100,    Z,       O, 32'h2002000A, N, Z,            N};
        vecs[3]  = '{N, O, 32'h100,    N, N, Z,       Z,       32'h12345678, O, N, N, 32'h100,    Z,       N, 32'h2002000A, N, Z,            O};
        vecs[4]  = '{N, N, Z,          N, N, Z,       Z,       Z,            N, N, N, 32'h100,    Z,       N, 32'h2002000A, N, Z,            N};
        vecs[5]  = '{N, O, 32'h200,    O, O, 32'h40,  32'h55,  Z,            N, O, O, 32'h40,     32'h55,  N, 32'h2002000A, N, Z,            O};
        vecs[6]  = '{N, O, 32'h200,    O, O, 32'h40,  32'h55,  32'hAAAA0001, O, N, O, 32'h40,     32'h55,  N, 32'h2002000A, O, 32'hAAAA0001, O};
        vecs[7]  = '{N, O, 32'h200,    O, O, 32'h40,  32'h55,  Z,            N, O, N, 32'h200,    Z,       N, 32'h2002000A, N, 32'hAAAA0001, O};
        vecs[8]  = '{N, O, 32'h200,    N, N, Z,       Z,       32'hBBBB0002, O, N, N, 32'h200,    Z,       O, 32'hBBBB0002, N, 32'hAAAA0001, N};
        vecs[9]  = '{N, N, Z,          N, N, Z,       Z,       Z,            N, N, N, 32'h200,    Z,       N, 32'hBBBB0002, N, 32'hAAAA0001, N};
        vecs[10] = '{N, N, Z,          O, N, 32'h80,  32'h77,  Z,            N, O, N, 32'h80,     32'h77,  N, 32'hBBBB0002, N, 32'hAAAA0001, O};
        vecs[11] = '{N, N, Z,          N, N, Z,       Z,       Z,            N, O, N, 32'h80,     32'h77,  N, 32'hBBBB0002, N, 32'hAAAA0001, N};
        vecs[12] = '{N, N, Z,          N, N, Z,       Z,       32'hCCCC0003, O, N, N, 32'h80,     32'h77,  N, 32'hBBBB0002, O, 32'hCCCC0003, N};
        vecs[13] = '{N, N, Z,          N, N, Z,       Z,       Z,            N, N, N, 32'h80,     32'h77,  N, 32'hBBBB0002, N, 32'hCCCC0003, N};

        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
        if_addr = Z; dm_addr = Z; dm_wdata = Z; mem_rdata = Z;
        step();

        for (int i = 0; i < 14; i++) begin
            rst = vecs[i].rst; if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we; dm_addr = vecs[i].dm_addr;
            dm_wdata = vecs[i].dm_wdata; mem_rdata = vecs[i].mem_rdata; mem_ack = vecs[i].mem_ack;
            step();
            chk($sformatf("v%0d mem_req", i),   {31'b0, mem_req},  {31'b0, vecs[i].e_mem_req});
            chk($sformatf("v%0d mem_we", i),    {31'b0, mem_we},   {31'b0, vecs[i].e_mem_we});
            chk($sformatf("v%0d mem_addr", i),  mem_addr,          vecs[i].e_mem_addr);
            chk($sformatf("v%0d mem_wdata", i), mem_wdata,         vecs[i].e_mem_wdata);
            chk($sformatf("v%0d if_ready", i),  {31'b0, if_ready}, {31'b0, vecs[i].e_if_ready});
            chk($sformatf("v%0d if_rdata", i),  if_rdata,          vecs[i].e_if_rdata);
            chk($sformatf("v%0d dm_ready", i),  {31'b0, dm_ready}, {31'b0, vecs[i].e_dm_ready});
            chk($sformatf("v%0d dm_rdata", i),  dm_rdata,          vecs[i].e_dm_rdata);
            chk($sformatf("v%0d stall", i),     {31'b0, stall},    {31'b0, vecs[i].e_stall});
            chk($sformatf("v%0d err", i),       {31'b0, err},      32'h0);
        end

        // Starvation: back-to-back stores with instant ack. if_req is withheld only in the
        // dm_ready cycle, where data is ineligible and a fetch would otherwise slip in.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h500; dm_wdata = 32'h5;
        if_req = 1'b1; if_addr = 32'h600; mem_ack = 1'b1; mem_rdata = 32'h1;
        prev = 1'b0; ng = 0;
        for (int c = 0; c < 60 && ng < 5; c++) begin
            step();
            if (mem_req && !prev) begin
                grants[ng] = mem_we;
                if (ng == 4) chk("starve fetch addr", mem_addr, 32'h600);
                ng++;
            end
            prev   = mem_req;
            if_req = ~dm_ready;
            if (ng == 5) begin dm_req = 1'b0; if_req = 1'b1; end
        end
        chk("starve grant count", ng, 5);
        for (int i = 0; i < 5; i++)
            if (i < ng) chk($sformatf("starve grant%0d is_data", i), {31'b0, grants[i]}, (i < 4) ? 32'h1 : 32'h0);
        step();
        chk("starve fetch if_ready", {31'b0, if_ready}, 32'h1);
        chk("starve fetch if_rdata", if_rdata, 32'h1);
        if_req = 1'b0; mem_ack = 1'b0;
        step();

        // Reset in the middle of a data transaction; the ack arrives three cycles after the grant.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        step();
        chk("rst pre mem_req", {31'b0, mem_req}, 32'h1);
        chk("rst pre mem_addr", mem_addr, 32'h300);
        step();
        rst = 1'b1;
        step();
        chk("rst mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst dm_rdata", dm_rdata, 32'h0);
        chk("rst if_rdata", if_rdata, 32'h0);
        rst = 1'b0; dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hEEEE0000;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("late ack dm_ready c%0d", c), {31'b0, dm_ready}, 32'h0);
            chk($sformatf("late ack mem_req c%0d", c), {31'b0, mem_req}, 32'h0);
        end
        chk("late ack dm_rdata", dm_rdata, 32'h0);
        mem_ack = 1'b0;

        // Memory never answers.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h400; dm_wdata = 32'h99;
        step();
        chk("nack mem_req", {31'b0, mem_req}, 32'h1);
        hi = 1; seen_ready = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int c = 0; c < 30 && mem_req; c++) begin
            step();
            if (mem_req) hi++;
        end
        chk("tmo mem_req cycles", hi, 8);
        chk("tmo dm_ready", {31'b0, dm_ready}, 32'h1);
        chk("tmo dm_rdata", dm_rdata, 32'hDEADBEEF);
        chk("tmo err", {31'b0, err}, 32'h1);
        dm_req = 1'b0;
        step(); step(); step();
        chk("tmo err sticky", {31'b0, err}, 32'h1);
`else
        for (int c = 0; c < 40; c++) begin
            step();
            if (mem_req) hi++;
            if (dm_ready) seen_ready = 1'b1;
        end
        chk("wait mem_req cycles", hi, 41);
        chk("wait no dm_ready", {31'b0, seen_ready}, 32'h0);
        chk("wait err", {31'b0, err}, 32'h0);
        dm_req = 1'b0;
`endif
        rst = 1'b1;
        step();
        chk("final rst err", {31'b0, err}, 32'h0);
        chk("final rst mem_req", {31'b0, mem_req}, 32'h0);
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
